multiple_comparator_tree: RTL and testbench
===========================================

Name: multiple_comparator_tree

Overview:
- Parametrised, fully pipelined min/max reduction tree over N unsigned W-bit inputs.
- Selects per sample between min and max mode and reports both the winning value and its input index.
- Uses ready/valid handshakes on input and output, with whole-pipeline stall under backpressure.
- Successor to the fixed 6x3-bit min tree; used by fuzzy inference stages that need rule-strength min/max plus argmax/argmin.

Parameters:
- N, 6, number of input channels; N >= 2.
- W, 3, data width of each input in bits; W >= 1.
- Derived, not user-set: LEVELS = ceil(log2(N)), IW = max(1, ceil(log2(N))).

Ports:
- clock  in  1  single clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_in_valid  in  1  input sample valid.
- io_in_ready  out  1  block can accept a sample this cycle.
- io_mode  in  1  0 = min, 1 = max; sampled with the data and carried down the pipeline.
- io_inputs  in  N*W  channel k occupies bits [k*W+W-1 : k*W]; channel 0 in the LSBs.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  downstream accepts the result.
- io_result  out  W  winning value.
- io_index  out  IW  channel number of the winning value.
- io_mode_out  out  1  mode that produced this result.

Behaviour:
- Tree structure: level L (1..LEVELS) pairs adjacent entries of level L-1. Level 0 is the input channels with index = k. An odd leftover entry passes through the level unchanged, value and index, but is still registered.
- Every level has a register stage holding, per entry: value (W), index (IW), plus one valid bit and one mode bit per level.
- Pair compare is unsigned. "Left" is the lower-index entry of the pair.
  - Min mode: take right only if right < left.
  - Max mode: take right only if right > left.
  - Ties always keep the left entry, so the lowest channel index wins on ties.
- Advance: adv = ~io_out_valid | io_out_ready. io_in_ready = adv, a combinational function of io_out_valid and io_out_ready only.
- When adv = 1, all stages shift one level. Stage-1 valid is loaded with io_in_valid; when io_in_valid = 0, a bubble enters and the data registers may load don't-care values.
- When adv = 0, every register holds and outputs remain stable.
- Latency: a sample accepted at edge t appears with io_out_valid = 1 after edge t+LEVELS-1, i.e. LEVELS edges after and including acceptance, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one sample per cycle while io_out_ready = 1. Bubbles are not collapsed.
- io_result, io_index and io_mode_out are driven directly from the final stage registers; there is no combinational path from the inputs to the outputs.
- Reset values: every valid bit = 0, every value = 0, every index = 0, every mode bit = 0. Therefore io_out_valid = 0, io_result = 0, io_index = 0, io_mode_out = 0, and io_in_ready = 1.
- Reset asserted mid-operation flushes all in-flight samples; none of them are ever output.
- The first accept is possible on the first rising edge after reset deasserts.
- Simultaneous output handshake and input accept in the same cycle is legal; no sample is lost or duplicated.
- io_mode changing between consecutive samples is legal. Each sample uses its own captured mode.
- N = 2 gives LEVELS = 1, a single registered stage.
- A power-of-two N has no pass-through entries.

Test Plan:
- N=6, W=3; reset, then one sample io_inputs = {ch0..ch5} = {5,2,7,2,0,7} with io_mode = 0 and io_out_ready = 1 -> exactly 3 cycles later io_out_valid = 1, io_result = 0, io_index = 4, io_mode_out = 0, for one cycle only.
- Same inputs with io_mode = 1 -> io_result = 7, io_index = 2 (tie with ch5 resolves to the lower index). Next, {3,3,3,3,3,3} with mode 0 -> result 3, index 0.
- Back-to-back: 4 samples on consecutive cycles with alternating modes -> 4 consecutive valid outputs, in order, each with correct value, index and mode_out.
- Backpressure: hold io_out_ready = 0 after the first result reaches the output -> io_in_ready = 0. Outputs stay frozen for 5 cycles. Release io_out_ready -> the remaining in-flight results emerge in order, none dropped or duplicated.
- Assert reset asynchronously between edges with 2 samples in flight -> io_out_valid drops to 0 immediately and io_result = 0. After deassert, no stale result ever appears.
- Parameter sweep: N=2, W=8 and N=8, W=4 with random stimulus checked against a reference model (value, index, lowest-index tie rule, latency = LEVELS). Include extremes 0 and 2^W-1.

Source files
------------

// File: rtl/multiple_comparator_tree.sv
// Pipelined min/max reduction tree over N unsigned W-bit channels.
// Each level pairs adjacent entries of the previous level (lower index on the
// left, ties keep the left entry) and registers the survivors together with
// the sample's valid and mode bits. The whole pipeline advances together and
// stalls as a unit when the output is held by backpressure.
module multiple_comparator_tree #(
  parameter  int N      = 6,
  parameter  int W      = 3,
  localparam int LEVELS = $clog2(N),
  localparam int IW     = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic            io_mode,
  input  logic [N*W-1:0]  io_inputs,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [W-1:0]    io_result,
  output logic [IW-1:0]   io_index,
  output logic            io_mode_out
);

  // Number of entries surviving at a given level of the tree.
  function automatic int unsigned level_count(input int unsigned lvl);
    int unsigned c;
    c = N;
    for (int unsigned i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  logic adv;

  assign adv         = ~io_out_valid | io_out_ready;
  assign io_in_ready = adv;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT = level_count(l);

    logic [W-1:0]  val [CNT];
    logic [IW-1:0] idx [CNT];
    logic          vld;
    logic          md;

    if (l == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_ch
        assign val[k] = io_inputs[k*W +: W];
        assign idx[k] = IW'(k);
      end
      assign vld = io_in_valid;
      assign md  = io_mode;
    end else begin : g_stage
      localparam int unsigned PCNT = level_count(l - 1);

      logic [W-1:0]  nval [CNT];
      logic [IW-1:0] nidx [CNT];

      for (genvar j = 0; j < CNT; j++) begin : g_ent
        if (2*j + 1 < PCNT) begin : g_pair
          logic take_right;
          // Strict compare keeps the left (lower-index) entry on ties.
          assign take_right = g_lvl[l-1].md
                            ? (g_lvl[l-1].val[2*j+1] > g_lvl[l-1].val[2*j])
                            : (g_lvl[l-1].val[2*j+1] < g_lvl[l-1].val[2*j]);
          assign nval[j] = take_right ? g_lvl[l-1].val[2*j+1] : g_lvl[l-1].val[2*j];
          assign nidx[j] = take_right ? g_lvl[l-1].idx[2*j+1] : g_lvl[l-1].idx[2*j];
        end else begin : g_pass
          assign nval[j] = g_lvl[l-1].val[2*j];
          assign nidx[j] = g_lvl[l-1].idx[2*j];
        end
      end

      // Stage register: shifts in the previous level's winners when the pipe advances.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld <= 1'b0;
          md  <= 1'b0;
          for (int unsigned j = 0; j < CNT; j++) begin
            val[j] <= '0;
            idx[j] <= '0;
          end
        end else if (adv) begin
          vld <= g_lvl[l-1].vld;
          md  <= g_lvl[l-1].md;
          for (int unsigned j = 0; j < CNT; j++) begin
            val[j] <= nval[j];
            idx[j] <= nidx[j];
          end
        end
      end
    end
  end

  assign io_out_valid = g_lvl[LEVELS].vld;
  assign io_result    = g_lvl[LEVELS].val[0];
  assign io_index     = g_lvl[LEVELS].idx[0];
  assign io_mode_out  = g_lvl[LEVELS].md;

endmodule

// File: tb/tb_multiple_comparator_tree.sv
// Testbench for multiple_comparator_tree: directed table vectors and multi-cycle
// sequences on the default 6x3 configuration, plus random sweeps on 2x8 and
// 8x4 instances checked against a linear-scan reference.
module tb_multiple_comparator_tree;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Default configuration N=6, W=3
  logic        m_in_valid, m_in_ready, m_mode, m_out_valid, m_out_ready, m_mode_out;
  logic [17:0] m_inputs;
  logic [2:0]  m_result, m_index;

  multiple_comparator_tree dut (
    .clock(clock), .reset(reset),
    .io_in_valid(m_in_valid), .io_in_ready(m_in_ready), .io_mode(m_mode),
    .io_inputs(m_inputs), .io_out_valid(m_out_valid), .io_out_ready(m_out_ready),
    .io_result(m_result), .io_index(m_index), .io_mode_out(m_mode_out)
  );

  // N=2, W=8
  logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_mode_out;
  logic [15:0] a_inputs;
  logic [7:0]  a_result;
  logic [0:0]  a_index;

  multiple_comparator_tree #(.N(2), .W(8)) dut2 (
    .clock(clock), .reset(reset),
    .io_in_valid(a_in_valid), .io_in_ready(a_in_ready), .io_mode(a_mode),
    .io_inputs(a_inputs), .io_out_valid(a_out_valid), .io_out_ready(a_out_ready),
    .io_result(a_result), .io_index(a_index), .io_mode_out(a_mode_out)
  );

  // N=8, W=4
  logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_mode_out;
  logic [31:0] b_inputs;
  logic [3:0]  b_result;
  logic [2:0]  b_index;

  multiple_comparator_tree #(.N(8), .W(4)) dut8 (
    .clock(clock), .reset(reset),
    .io_in_valid(b_in_valid), .io_in_ready(b_in_ready), .io_mode(b_mode),
    .io_inputs(b_inputs), .io_out_valid(b_out_valid), .io_out_ready(b_out_ready),
    .io_result(b_result), .io_index(b_index), .io_mode_out(b_mode_out)
  );

  typedef struct packed {
    logic [17:0] in;
    logic        mode;
    logic [2:0]  res;
    logic [2:0]  idx;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic       m;
    logic [7:0] res;
    logic [2:0] idx;
  } exp_t;

  localparam int M = 40;

  int   checks;
  int   failures;
  vec_t tbl [11];
  exp_t h2 [M];
  exp_t h8 [M];
  int   stale;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input bit md, input int r, input int ix);
    vec_t v;
    v.in   = {3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    v.mode = md;
    v.res  = 3'(r);
    v.idx  = 3'(ix);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    m_in_valid = 1'b1;
    m_inputs   = v.in;
    m_mode     = v.mode;
  endtask

  task automatic expect_out(input string tag, input vec_t v);
    check({tag, "_valid"},  m_out_valid, 1);
    check({tag, "_result"}, m_result,    v.res);
    check({tag, "_index"},  m_index,     v.idx);
    check({tag, "_mode"},   m_mode_out,  v.mode);
  endtask

  function automatic void ref_pick(input int v[8], input int n, input bit md,
                                   output int res, output int ix);
    res = v[0];
    ix  = 0;
    for (int k = 1; k < n; k++) begin
      if (md ? (v[k] > res) : (v[k] < res)) begin
        res = v[k];
        ix  = k;
      end
    end
  endfunction

  function automatic int rand_val(input int maxv);
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 0;
    if (r == 1) return maxv;
    return int'($urandom_range(0, maxv));
  endfunction

  // Drive sample j of both sweep instances and record its expected result.
  task automatic drive_sweep(input int j);
    int v[8];
    int res, ix;
    bit md;
    if (j >= M) begin
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      return;
    end
    // N=2, W=8
    for (int k = 0; k < 8; k++) v[k] = 0;
    for (int k = 0; k < 2; k++) begin
      v[k] = rand_val(255);
      a_inputs[k*8 +: 8] = 8'(v[k]);
    end
    md         = 1'($urandom_range(0, 1));
    a_mode     = md;
    a_in_valid = ($urandom_range(0, 3) != 0);
    ref_pick(v, 2, md, res, ix);
    h2[j] = '{v: a_in_valid, m: md, res: 8'(res), idx: 3'(ix)};
    // N=8, W=4
    for (int k = 0; k < 8; k++) begin
      v[k] = rand_val(15);
      b_inputs[k*4 +: 4] = 4'(v[k]);
    end
    md         = 1'($urandom_range(0, 1));
    b_mode     = md;
    b_in_valid = ($urandom_range(0, 3) != 0);
    ref_pick(v, 8, md, res, ix);
    h8[j] = '{v: b_in_valid, m: md, res: 8'(res), idx: 3'(ix)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m_in_valid = 1'b0; m_mode = 1'b0; m_inputs = '0; m_out_ready = 1'b1;
    a_in_valid = 1'b0; a_mode = 1'b0; a_inputs = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_mode = 1'b0; b_inputs = '0; b_out_ready = 1'b1;

    tbl[0]  = mk(5, 2, 7, 2, 0, 7, 1'b0, 0, 4);
    tbl[1]  = mk(5, 2, 7, 2, 0, 7, 1'b1, 7, 2);
    tbl[2]  = mk(3, 3, 3, 3, 3, 3, 1'b0, 3, 0);
    tbl[3]  = mk(3, 3, 3, 3, 3, 3, 1'b1, 3, 0);
    tbl[4]  = mk(7, 7, 7, 7, 7, 0, 1'b0, 0, 5);
    tbl[5]  = mk(1, 6, 4, 6, 2, 5, 1'b1, 6, 1);
    tbl[6]  = mk(4, 5, 6, 7, 1, 2, 1'b0, 1, 4);
    tbl[7]  = mk(0, 7, 0, 7, 0, 7, 1'b0, 0, 0);
    tbl[8]  = mk(0, 7, 0, 7, 0, 7, 1'b1, 7, 1);
    tbl[9]  = mk(6, 5, 4, 3, 2, 1, 1'b0, 1, 5);
    tbl[10] = mk(6, 5, 4, 3, 2, 1, 1'b1, 6, 0);

    #12;
    reset = 1'b0;
    #1;
    check("rst_out_valid", m_out_valid, 0);
    check("rst_result",    m_result,    0);
    check("rst_index",     m_index,     0);
    check("rst_mode_out",  m_mode_out,  0);
    check("rst_in_ready",  m_in_ready,  1);

    // Single samples: valid exactly LEVELS=3 edges after acceptance, for one cycle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      apply(tbl[i]);
      @(negedge clock);
      m_in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), m_out_valid, 0);
      @(negedge clock);
      check($sformatf("vec%0d_lat2", i), m_out_valid, 0);
      @(negedge clock);
      expect_out($sformatf("vec%0d", i), tbl[i]);
      @(negedge clock);
      check($sformatf("vec%0d_after", i), m_out_valid, 0);
    end

    // Back-to-back with alternating modes.
    @(negedge clock);
    apply(tbl[0]);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      if (k >= 2 && k <= 5) expect_out($sformatf("b2b%0d", k - 2), tbl[k-2]);
      else                  check($sformatf("b2b_idle%0d", k), m_out_valid, 0);
      if (k < 3) apply(tbl[k+1]);
      else       m_in_valid = 1'b0;
    end

    // Backpressure: freeze with result at the output, then drain in order.
    @(negedge clock);
    apply(tbl[5]);
    @(negedge clock);
    apply(tbl[6]);
    @(negedge clock);
    apply(tbl[9]);
    @(negedge clock);
    expect_out("bp_first", tbl[5]);
    m_out_ready = 1'b0;
    apply(tbl[10]);
    #1;
    check("bp_in_ready_low", m_in_ready, 0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      expect_out($sformatf("bp_hold%0d", s), tbl[5]);
      check($sformatf("bp_hold%0d_in_ready", s), m_in_ready, 0);
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", m_in_ready, 1);
    @(negedge clock);
    expect_out("bp_drain0", tbl[6]);
    @(negedge clock);
    expect_out("bp_drain1", tbl[9]);
    @(negedge clock);
    check("bp_drain_end", m_out_valid, 0);

    // Asynchronous reset with two samples in flight behind a valid output.
    @(negedge clock);
    apply(tbl[2]);
    @(negedge clock);
    apply(tbl[5]);
    @(negedge clock);
    apply(tbl[6]);
    @(negedge clock);
    m_in_valid = 1'b0;
    expect_out("pre_reset", tbl[2]);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid",    m_out_valid, 0);
    check("async_rst_result",   m_result,    0);
    check("async_rst_index",    m_index,     0);
    check("async_rst_in_ready", m_in_ready,  1);
    @(negedge clock);
    #2;
    reset = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (m_out_valid !== 1'b0) stale++;
    end
    check("no_stale_after_reset", stale, 0);

    // Random sweep on N=2/W=8 (latency 1) and N=8/W=4 (latency 3).
    @(negedge clock);
    drive_sweep(0);
    for (int e = 0; e < M + 3; e++) begin
      int j2, j8;
      @(negedge clock);
      j2 = e;
      j8 = e - 2;
      if (j2 >= M) begin
        check($sformatf("n2_idle%0d", e), a_out_valid, 0);
      end else begin
        check($sformatf("n2_s%0d_valid", j2), a_out_valid, h2[j2].v);
        if (h2[j2].v) begin
          check($sformatf("n2_s%0d_result", j2), a_result,   h2[j2].res);
          check($sformatf("n2_s%0d_index", j2),  a_index,    h2[j2].idx);
          check($sformatf("n2_s%0d_mode", j2),   a_mode_out, h2[j2].m);
        end
      end
      if (j8 < 0 || j8 >= M) begin
        check($sformatf("n8_idle%0d", e), b_out_valid, 0);
      end else begin
        check($sformatf("n8_s%0d_valid", j8), b_out_valid, h8[j8].v);
        if (h8[j8].v) begin
          check($sformatf("n8_s%0d_result", j8), b_result,   h8[j8].res);
          check($sformatf("n8_s%0d_index", j8),  b_index,    h8[j8].idx);
          check($sformatf("n8_s%0d_mode", j8),   b_mode_out, h8[j8].m);
        end
      end
      drive_sweep(e + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
